async_trigger_receiver: RTL
===========================

# async_trigger_receiver

Parametrised front-panel trigger receiver for asynchronous mode. It detects rising edges on the front-panel trigger and forwards one pulse per accepted trigger to the channel acquisition controllers. It classifies each trigger by its length, tracks per-channel DDR3 occupancy against the AMC13 event-size limit, and pushes trigger information words into the Pulse Trigger FIFO. It replaces the fixed 5-channel receiver and adds three things: configurable channel count and sampling window, a programmable holdoff, and counting of triggers missed while busy.

## Interface
Parameters:
- NUM_CHAN, 5, number of channels
- BC_W, 23, burst-count / stored-burst width
- EVENT_LIMIT, 524288, maximum stored bursts per channel (less than 2^BC_W)
- WIN, 4, trigger-level sampling window in cycles (at least 2)
- TN_W, 24, trigger number width
- TS_W, 44, timestamp width (2+TN_W+TS_W must not exceed 128)

Ports:
- clk  in  1  40 MHz TTC clock
- reset_n  in  1  asynchronous, active-low reset
- reset_trig_num, reset_trig_timestamp  in  1  TTC Channel B resets
- trigger  in  1  front-panel trigger, already synchronised to clk
- async_mode, accept_pulse_triggers  in  1  enables
- chan_en  in  NUM_CHAN  channel enables
- burst_count  in  NUM_CHAN*BC_W  per-channel burst count minus 1; channel i is in bits [i*BC_W +: BC_W]
- thres_ddr3_overflow  in  BC_W  almost-full threshold
- holdoff  in  16  dead-time cycles after each FIFO write
- readout_done  in  1  readout complete
- fifo_ready  in  1  FIFO accepts a word
- pulse_trigger  out  1  channel trigger pulse
- trig_num  out  TN_W  global trigger number
- fifo_valid  out  1  FIFO word valid
- fifo_data  out  128  {zeros, trig_length[1:0], trig_num, trig_timestamp}
- stored_bursts  out  NUM_CHAN*BC_W  per-channel DDR3 occupancy
- state  out  5  one-hot FSM state
- ddr3_overflow_count, missed_trig_count  out  32  saturating error counters
- ddr3_full_chan  out  NUM_CHAN  per-channel full flags
- ddr3_almost_full  out  1  OR over channels of (stored_bursts > thres)

## Operation
- Reset values: every output is 0, except state = IDLE (bit 0). Any pending FIFO word is discarded.
- Rising edge is defined as trigger=1 with the registered previous level equal to 0. Only edges can start a trigger.
- The trigger timestamp counter is TS_W bits, free-running, and wraps modulo 2^TS_W.
- ddr3_full_chan[i] = chan_en[i] & ((EVENT_LIMIT - stored_i) < (burst_count_i + 1)). This is computed in BC_W+1 bits and is combinational.
- FSM states:
  - IDLE: on an edge with async_mode and accept_pulse_triggers both high:
    - if any ddr3_full_chan bit is set: ddr3_overflow_count +1 and stay in IDLE;
    - otherwise: trig_num +1, latch the timestamp counter, take sample 0, go to SEND.
  - SEND: assert pulse_trigger next cycle, take sample 1, go to SAMPLE.
  - SAMPLE: take samples 2..WIN-1, then spend one extra cycle registering the class, then go to STORE.
    - trig_length = 2'b10 (laser) if the last sample is 0;
    - else 2'b01 (Am) if all WIN samples are 1;
    - else 2'b11 (laser+Am).
  - STORE: fifo_valid=1 with fifo_data stable. On fifo_valid & fifo_ready, go to HOLDOFF, or to IDLE if holdoff=0.
  - HOLDOFF: count holdoff cycles, then go to IDLE.
- An edge seen in SEND, SAMPLE, STORE or HOLDOFF increments missed_trig_count. It is otherwise ignored.
- Deasserting async_mode or accept_pulse_triggers mid-sequence does not abort the sequence; it completes normally.
- stored_bursts: in a cycle with pulse_trigger=1, stored_i += chan_en[i]*(burst_count_i+1).
- readout_done clears trig_num and stored_bursts. The clear wins over a simultaneous increment.
- reset_trig_num clears trig_num and wins over an increment. reset_trig_timestamp clears the timestamp counter and the latched timestamp.
- Error counters saturate at 32'hFFFFFFFF.

## Timing
- Edge accepted at cycle T:
  - state=SEND at T+1;
  - pulse_trigger=1 during T+2 only;
  - trig_num updated at T+1;
  - latched timestamp = counter value at T.
- Samples are taken at cycles T .. T+WIN-1. trig_length is registered by T+WIN+1.
- fifo_valid rises at T+WIN+2 (T+6 for WIN=4) and holds until the handshake cycle H. It is 0 from H+1.
- IDLE is re-entered at H+1+holdoff. An edge at that cycle is accepted.
- stored_bursts update at T+3. ddr3_full_chan and ddr3_almost_full follow combinationally.

## Test plan
- Short pulse, WIN=4: trigger high 2 cycles, fifo_ready=1 -> one pulse_trigger, trig_num=1, FIFO word with trig_length=2'b10 and the timestamp of edge cycle T, fifo_valid high for 1 cycle at T+6.
- Long pulse high 10 cycles -> trig_length=2'b01. Pattern 1,0,1,1 -> 2'b11. A level held high with no new edge yields no second trigger.
- Overflow: NUM_CHAN=2, burst_count_0=262143, chan_en=2'b01, three edges -> two accepted (stored_0=524288), third gives ddr3_overflow_count=1 and no pulse. Then readout_done -> stored=0, trig_num=0.
- Backpressure and missed triggers: fifo_ready=0 for 20 cycles, three edges during STORE -> fifo_data stable, missed_trig_count=3, single FIFO write when ready rises.
- Holdoff=8: edge at H+5 -> missed_trig_count +1. Edge at H+9 -> accepted.
- reset_n low during SAMPLE -> all outputs 0 immediately, state=IDLE. Coincident readout_done and pulse_trigger -> stored=0.

Source files
------------

// File: rtl/async_trigger_receiver.sv
// Front-panel trigger receiver for asynchronous mode: edge detect, trigger-length classification,
// per-channel DDR3 occupancy tracking and trigger-info word hand-off to the Pulse Trigger FIFO.
module async_trigger_receiver #(
  parameter int NUM_CHAN    = 5,
  parameter int BC_W        = 23,
  parameter int EVENT_LIMIT = 524288,
  parameter int WIN         = 4,
  parameter int TN_W        = 24,
  parameter int TS_W        = 44
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     reset_trig_num,
  input  logic                     reset_trig_timestamp,
  input  logic                     trigger,
  input  logic                     async_mode,
  input  logic                     accept_pulse_triggers,
  input  logic [NUM_CHAN-1:0]      chan_en,
  input  logic [NUM_CHAN*BC_W-1:0] burst_count,
  input  logic [BC_W-1:0]          thres_ddr3_overflow,
  input  logic [15:0]              holdoff,
  input  logic                     readout_done,
  input  logic                     fifo_ready,
  output logic                     pulse_trigger,
  output logic [TN_W-1:0]          trig_num,
  output logic                     fifo_valid,
  output logic [127:0]             fifo_data,
  output logic [NUM_CHAN*BC_W-1:0] stored_bursts,
  output logic [4:0]               state,
  output logic [31:0]              ddr3_overflow_count,
  output logic [31:0]              missed_trig_count,
  output logic [NUM_CHAN-1:0]      ddr3_full_chan,
  output logic                     ddr3_almost_full
);

  localparam int IDX_W = $clog2(WIN + 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] WIN_I   = IDX_W'(WIN);
  localparam logic [BC_W:0]    LIMIT   = (BC_W+1)'(EVENT_LIMIT);
  localparam logic [BC_W:0]    BC_ONE  = (BC_W+1)'(1);
  localparam logic [BC_W-1:0]  BQ_ONE  = BC_W'(1);
  localparam logic [TN_W-1:0]  TN_ONE  = TN_W'(1);
  localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    SEND    = 5'b00010,
    SAMPLE  = 5'b00100,
    STORE   = 5'b01000,
    HOLDOFF = 5'b10000
  } state_t;

  state_t                   state_q, state_d;
  logic                     trig_prev_q;
  logic                     pulse_q, pulse_d;
  logic                     fifo_valid_q, fifo_valid_d;
  logic [WIN-1:0]           samp_q, samp_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [1:0]               trig_length_q, trig_length_d;
  logic [TN_W-1:0]          trig_num_q, trig_num_d;
  logic [TN_W-1:0]          tnum_lat_q, tnum_lat_d;
  logic [TS_W-1:0]          ts_cnt_q, ts_cnt_d;
  logic [TS_W-1:0]          ts_lat_q, ts_lat_d;
  logic [NUM_CHAN*BC_W-1:0] stored_q, stored_d;
  logic [15:0]              hold_q, hold_d;
  logic [31:0]              ovf_q, ovf_d;
  logic [31:0]              missed_q, missed_d;
  logic                     trig_edge, accept;
  logic [BC_W:0]            room, need;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Samples shift in at bit 0, so bit 0 holds the last sample of the window.
  function automatic logic [1:0] classify(input logic [WIN-1:0] s);
    if (!s[0])   return 2'b10;
    else if (&s) return 2'b01;
    else         return 2'b11;
  endfunction

  assign trig_edge = trigger & ~trig_prev_q;

  always_comb begin
    ddr3_full_chan   = '0;
    ddr3_almost_full = 1'b0;
    room             = '0;
    need             = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      room = LIMIT - {1'b0, stored_q[i*BC_W +: BC_W]};
      need = {1'b0, burst_count[i*BC_W +: BC_W]} + BC_ONE;
      ddr3_full_chan[i] = chan_en[i] & (room < need);
      if (stored_q[i*BC_W +: BC_W] > thres_ddr3_overflow) ddr3_almost_full = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    pulse_d       = 1'b0;
    fifo_valid_d  = fifo_valid_q;
    samp_d        = samp_q;
    idx_d         = idx_q;
    trig_length_d = trig_length_q;
    trig_num_d    = trig_num_q;
    tnum_lat_d    = tnum_lat_q;
    ts_cnt_d      = ts_cnt_q + TS_ONE;
    ts_lat_d      = ts_lat_q;
    stored_d      = stored_q;
    hold_d        = hold_q;
    ovf_d         = ovf_q;
    missed_d      = missed_q;
    accept        = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig_edge && async_mode && accept_pulse_triggers) begin
          if (|ddr3_full_chan) begin
            ovf_d = sat_inc(ovf_q);
          end else begin
            accept   = 1'b1;
            ts_lat_d = ts_cnt_q;
            samp_d   = {{(WIN-1){1'b0}}, trigger};
            idx_d    = IDX_ONE;
            state_d  = SEND;
          end
        end
      end
      SEND: begin
        pulse_d = 1'b1;
        samp_d  = {samp_q[WIN-2:0], trigger};
        idx_d   = idx_q + IDX_ONE;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        if (idx_q < WIN_I) begin
          samp_d = {samp_q[WIN-2:0], trigger};
          idx_d  = idx_q + IDX_ONE;
        end else begin
          trig_length_d = classify(samp_q);
          state_d       = STORE;
        end
      end
      STORE: begin
        if (!fifo_valid_q) begin
          fifo_valid_d = 1'b1;
        end else if (fifo_ready) begin
          fifo_valid_d = 1'b0;
          if (holdoff == 16'd0) begin
            state_d = IDLE;
          end else begin
            hold_d  = holdoff;
            state_d = HOLDOFF;
          end
        end
      end
      HOLDOFF: begin
        if (hold_q <= 16'd1) state_d = IDLE;
        else                 hold_d  = hold_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    if (trig_edge && (state_q != IDLE)) missed_d = sat_inc(missed_q);

    if (readout_done || reset_trig_num) trig_num_d = '0;
    else if (accept)                    trig_num_d = trig_num_q + TN_ONE;
    if (accept) tnum_lat_d = trig_num_d;

    if (reset_trig_timestamp) begin
      ts_cnt_d = '0;
      ts_lat_d = '0;
    end

    if (pulse_q) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (chan_en[i])
          stored_d[i*BC_W +: BC_W] = stored_q[i*BC_W +: BC_W] + burst_count[i*BC_W +: BC_W] + BQ_ONE;
      end
    end
    if (readout_done) stored_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      trig_prev_q   <= 1'b0;
      pulse_q       <= 1'b0;
      fifo_valid_q  <= 1'b0;
      samp_q        <= '0;
      idx_q         <= '0;
      trig_length_q <= '0;
      trig_num_q    <= '0;
      tnum_lat_q    <= '0;
      ts_cnt_q      <= '0;
      ts_lat_q      <= '0;
      stored_q      <= '0;
      hold_q        <= '0;
      ovf_q         <= '0;
      missed_q      <= '0;
    end else begin
      state_q       <= state_d;
      trig_prev_q   <= trigger;
      pulse_q       <= pulse_d;
      fifo_valid_q  <= fifo_valid_d;
      samp_q        <= samp_d;
      idx_q         <= idx_d;
      trig_length_q <= trig_length_d;
      trig_num_q    <= trig_num_d;
      tnum_lat_q    <= tnum_lat_d;
      ts_cnt_q      <= ts_cnt_d;
      ts_lat_q      <= ts_lat_d;
      stored_q      <= stored_d;
      hold_q        <= hold_d;
      ovf_q         <= ovf_d;
      missed_q      <= missed_d;
    end
  end

  assign pulse_trigger       = pulse_q;
  assign trig_num            = trig_num_q;
  assign fifo_valid          = fifo_valid_q;
  assign fifo_data           = 128'({trig_length_q, tnum_lat_q, ts_lat_q});
  assign stored_bursts       = stored_q;
  assign state               = state_q;
  assign ddr3_overflow_count = ovf_q;
  assign missed_trig_count   = missed_q;

endmodule
